// File: rtl/manager_rx_frame_if.sv
// Receive-frame bus between the UART receiver, the frame assembler and the
// command manager.
//   RS_DATAOUT/RS_DONE         : received byte and its one-cycle strobe
//   frame_valid/cmd_rx/addr_rx/
//   data_rx                    : last good frame and its one-cycle pulse
//   frame_err/err_code         : discard pulse and held cause (01 csum, 10 timeout)
//   busy                       : a frame is partly received
// slave = frame assembler side, master = byte source / frame consumer side.
interface manager_rx_frame_if #(
   parameter int ADDR_BYTES = 1,
   parameter int DATA_BYTES = 1
);
   logic [7:0]              RS_DATAOUT;
   logic                    RS_DONE;
   logic                    frame_valid;
   logic [7:0]              cmd_rx;
   logic [8*ADDR_BYTES-1:0] addr_rx;
   logic [8*DATA_BYTES-1:0] data_rx;
   logic                    frame_err;
   logic [1:0]              err_code;
   logic                    busy;

   modport slave (
      input  RS_DATAOUT, RS_DONE,
      output frame_valid, cmd_rx, addr_rx, data_rx, frame_err, err_code, busy
   );

   modport master (
      output RS_DATAOUT, RS_DONE,
      input  frame_valid, cmd_rx, addr_rx, data_rx, frame_err, err_code, busy
   );
endinterface

// File: rtl/manager_rx_frame.sv
// Receive-frame assembler: cmd byte, ADDR_BYTES address bytes, DATA_BYTES data
// bytes and an optional XOR checksum byte, with an inter-byte timeout.
// Only complete, good frames update cmd_rx/addr_rx/data_rx.
// Ports:
//   CLK_50MHZ : system clock (rising edge)
//   RST_N     : asynchronous active-low reset
//   bus       : manager_rx_frame_if.slave (byte strobe in, frame/error out)
//
// state  | meaning
// S_CMD  | idle, waiting for the command byte
// S_ADDR | collecting address bytes
// S_DATA | collecting data bytes
// S_CSUM | waiting for the checksum byte
module manager_rx_frame #(
   parameter int ADDR_BYTES     = 1,
   parameter int DATA_BYTES     = 1,
   parameter bit CHECKSUM_EN    = 1'b1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  CLK_50MHZ,
   input  logic                  RST_N,
   manager_rx_frame_if.slave     bus
);

   localparam int AW   = 8 * ADDR_BYTES;
   localparam int DW   = 8 * DATA_BYTES;
   localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;
   localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
   localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
   localparam logic [TW-1:0]  T_LAST    =
      TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      S_CMD  = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_CSUM = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [BCW-1:0]  bcnt_q, bcnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [7:0]      csum_q, csum_d;
   logic [7:0]      cmd_sh_q, cmd_sh_d;
   logic [AW-1:0]   addr_sh_q, addr_sh_d;
   logic [DW-1:0]   data_sh_q, data_sh_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            fv_q, fv_d;
   logic            fe_q, fe_d;
   logic [1:0]      code_q, code_d;
   logic            commit;

   logic            done;
   logic [7:0]      rx_byte;

   assign done    = bus.RS_DONE;
   assign rx_byte = bus.RS_DATAOUT;

   always_comb begin
      state_d   = state_q;
      bcnt_d    = bcnt_q;
      tcnt_d    = tcnt_q;
      csum_d    = csum_q;
      cmd_sh_d  = cmd_sh_q;
      addr_sh_d = addr_sh_q;
      data_sh_d = data_sh_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      data_d    = data_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;
      code_d    = code_q;
      commit    = 1'b0;

      case (state_q)
         S_CMD: begin
            if (done) begin
               cmd_sh_d  = rx_byte;
               addr_sh_d = '0;
               data_sh_d = '0;
               csum_d    = rx_byte;
               bcnt_d    = '0;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (done) begin
               // Shift-left insert keeps the first received byte as the MSB.
               addr_sh_d = (addr_sh_q << 8) | AW'(rx_byte);
               csum_d    = csum_q ^ rx_byte;
               if (bcnt_q == ADDR_LAST) begin
                  bcnt_d  = '0;
                  state_d = S_DATA;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (done) begin
               data_sh_d = (data_sh_q << 8) | DW'(rx_byte);
               csum_d    = csum_q ^ rx_byte;
               if (bcnt_q == DATA_LAST) begin
                  bcnt_d = '0;
                  if (CHECKSUM_EN) begin
                     state_d = S_CSUM;
                  end else begin
                     commit = 1'b1;
                  end
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         S_CSUM: begin
            if (done) begin
               if (rx_byte == csum_q) begin
                  commit = 1'b1;
               end else begin
                  fe_d      = 1'b1;
                  code_d    = 2'b01;
                  state_d   = S_CMD;
                  cmd_sh_d  = '0;
                  addr_sh_d = '0;
                  data_sh_d = '0;
               end
            end
         end
         default: state_d = S_CMD;
      endcase

      // Inter-byte timeout; a strobe in the expiry cycle wins over the timeout.
      if (state_q != S_CMD) begin
         if (done) begin
            tcnt_d = '0;
         end else if (TIMEOUT_CYCLES > 0) begin
            if (tcnt_q == T_LAST) begin
               tcnt_d    = '0;
               fe_d      = 1'b1;
               code_d    = 2'b10;
               state_d   = S_CMD;
               bcnt_d    = '0;
               cmd_sh_d  = '0;
               addr_sh_d = '0;
               data_sh_d = '0;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
      end

      // Commit uses the next-state shadows so the final byte is included.
      if (commit) begin
         cmd_d   = cmd_sh_d;
         addr_d  = addr_sh_d;
         data_d  = data_sh_d;
         fv_d    = 1'b1;
         state_d = S_CMD;
      end
   end

   always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_CMD;
         bcnt_q    <= '0;
         tcnt_q    <= '0;
         csum_q    <= '0;
         cmd_sh_q  <= '0;
         addr_sh_q <= '0;
         data_sh_q <= '0;
         cmd_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         fv_q      <= 1'b0;
         fe_q      <= 1'b0;
         code_q    <= '0;
      end else begin
         state_q   <= state_d;
         bcnt_q    <= bcnt_d;
         tcnt_q    <= tcnt_d;
         csum_q    <= csum_d;
         cmd_sh_q  <= cmd_sh_d;
         addr_sh_q <= addr_sh_d;
         data_sh_q <= data_sh_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         fv_q      <= fv_d;
         fe_q      <= fe_d;
         code_q    <= code_d;
      end
   end

   assign bus.frame_valid = fv_q;
   assign bus.frame_err   = fe_q;
   assign bus.cmd_rx      = cmd_q;
   assign bus.addr_rx     = addr_q;
   assign bus.data_rx     = data_q;
   assign bus.err_code    = code_q;
   assign bus.busy        = (state_q != S_CMD);

endmodule

// File: tb/tb_manager_rx_frame.sv
module tb_manager_rx_frame;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   typedef struct {
      logic        kind;   // 0 = frame_valid, 1 = frame_err
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [63:0] data;
      logic [1:0]  code;
      int          cyc;
   } exp_t;

   exp_t q_d[$];
   exp_t q_w[$];
   exp_t e_d, e_w;

   logic [7:0]  l_cmd;
   logic [31:0] l_addr;
   logic [63:0] l_data;
   logic [1:0]  l_code;
   int          c_last;

   manager_rx_frame_if #(.ADDR_BYTES(1), .DATA_BYTES(1)) bd ();
   manager_rx_frame_if #(.ADDR_BYTES(2), .DATA_BYTES(4)) bw ();

   manager_rx_frame u_def (
      .CLK_50MHZ (clk),
      .RST_N     (rst_n),
      .bus       (bd.slave)
   );

   manager_rx_frame #(
      .ADDR_BYTES  (2),
      .DATA_BYTES  (4),
      .CHECKSUM_EN (1'b0)
   ) u_wide (
      .CLK_50MHZ (clk),
      .RST_N     (rst_n),
      .bus       (bw.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_pulse(input string tag, input exp_t e, input logic fv, input logic fe,
                              input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [63:0] data, input logic [1:0] code);
      cmp({tag, "_valid"}, 64'(fv), 64'(!e.kind));
      cmp({tag, "_err"},   64'(fe), 64'(e.kind));
      cmp({tag, "_cmd"},   64'(cmd), 64'(e.cmd));
      cmp({tag, "_addr"},  64'(addr), 64'(e.addr));
      cmp({tag, "_data"},  data, e.data);
      cmp({tag, "_code"},  64'(code), 64'(e.code));
      cmp({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
   endtask

   // Scoreboard monitors: compare whenever a DUT presents a pulse.
   always @(negedge clk) begin
      if (rst_n && (bd.frame_valid || bd.frame_err)) begin
         if (q_d.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL def_unexpected_pulse valid=%0b err=%0b expected none (cycle %0d)",
                     bd.frame_valid, bd.frame_err, cyc);
         end else begin
            e_d = q_d.pop_front();
            check_pulse("def", e_d, bd.frame_valid, bd.frame_err, bd.cmd_rx,
                        32'(bd.addr_rx), 64'(bd.data_rx), bd.err_code);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (bw.frame_valid || bw.frame_err)) begin
         if (q_w.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wide_unexpected_pulse valid=%0b err=%0b expected none (cycle %0d)",
                     bw.frame_valid, bw.frame_err, cyc);
         end else begin
            e_w = q_w.pop_front();
            check_pulse("wide", e_w, bw.frame_valid, bw.frame_err, bw.cmd_rx,
                        32'(bw.addr_rx), 64'(bw.data_rx), bw.err_code);
         end
      end
   end

   task automatic drive_byte(input bit sel, input logic [7:0] b);
      @(negedge clk);
      if (sel) begin
         bw.RS_DATAOUT = b;
         bw.RS_DONE    = 1'b1;
      end else begin
         bd.RS_DATAOUT = b;
         bd.RS_DONE    = 1'b1;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bd.RS_DONE = 1'b0;
      bw.RS_DONE = 1'b0;
   endtask

   task automatic push(input bit sel, input logic kind, input logic [7:0] cmd,
                       input logic [31:0] addr, input logic [63:0] data,
                       input logic [1:0] code, input int c);
      exp_t e;
      e.kind = kind; e.cmd = cmd; e.addr = addr; e.data = data; e.code = code; e.cyc = c;
      if (sel) q_w.push_back(e);
      else     q_d.push_back(e);
   endtask

   // Four-byte frame on the default DUT; the result is known from the bytes
   // and the csum byte the caller supplies.
   task automatic frame_d(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input bit good);
      drive_byte(1'b0, b0);
      drive_byte(1'b0, b1);
      drive_byte(1'b0, b2);
      drive_byte(1'b0, b3);
      if (good) begin
         l_cmd  = b0;
         l_addr = 32'(b1);
         l_data = 64'(b2);
         push(1'b0, 1'b0, l_cmd, l_addr, l_data, l_code, cyc + 1);
      end else begin
         l_code = 2'b01;
         push(1'b0, 1'b1, l_cmd, l_addr, l_data, l_code, cyc + 1);
      end
   endtask

   task automatic wait_drain(input bit sel, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if ((sel ? q_w.size() : q_d.size()) == 0) break;
      end
      if ((sel ? q_w.size() : q_d.size()) != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_no_pulse pending=%0d expected 0",
                  sel ? "wide" : "def", sel ? q_w.size() : q_d.size());
         if (sel) q_w.delete();
         else     q_d.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      cmp({tag, "_fv"},   64'(bd.frame_valid), 64'(0));
      cmp({tag, "_fe"},   64'(bd.frame_err), 64'(0));
      cmp({tag, "_cmd"},  64'(bd.cmd_rx), 64'(0));
      cmp({tag, "_addr"}, 64'(bd.addr_rx), 64'(0));
      cmp({tag, "_data"}, 64'(bd.data_rx), 64'(0));
      cmp({tag, "_code"}, 64'(bd.err_code), 64'(0));
      cmp({tag, "_busy"}, 64'(bd.busy), 64'(0));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bd.RS_DONE = 1'b0; bd.RS_DATAOUT = 8'h00;
      bw.RS_DONE = 1'b0; bw.RS_DATAOUT = 8'h00;
      l_cmd = 8'h00; l_addr = '0; l_data = '0; l_code = 2'b00;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Good frame, 89 = A5^10^3C.
      frame_d(8'hA5, 8'h10, 8'h3C, 8'h89, 1'b1);
      idle();
      wait_drain(1'b0, 20);

      // Bad checksum: 01^02^03 = 00, FF sent.
      frame_d(8'h01, 8'h02, 8'h03, 8'hFF, 1'b0);
      idle();
      wait_drain(1'b0, 20);

      // Timeout after a partial frame.
      drive_byte(1'b0, 8'hA5);
      drive_byte(1'b0, 8'h10);
      c_last = cyc + 1;
      idle();
      cmp("to_busy_partial", 64'(bd.busy), 64'(1));
      l_code = 2'b10;
      push(1'b0, 1'b1, l_cmd, l_addr, l_data, l_code, c_last + 50000);
      wait_drain(1'b0, 60000);
      cmp("to_busy_after", 64'(bd.busy), 64'(0));
      frame_d(8'h11, 8'h22, 8'h33, 8'h00, 1'b1);
      idle();
      wait_drain(1'b0, 20);

      // Back-to-back: second cmd strobe lands in the frame_valid cycle.
      frame_d(8'h5A, 8'h01, 8'h02, 8'h59, 1'b1);
      frame_d(8'h7E, 8'h80, 8'h40, 8'hBE, 1'b1);
      idle();
      wait_drain(1'b0, 20);

      // Wide configuration, no checksum.
      drive_byte(1'b1, 8'h01);
      drive_byte(1'b1, 8'h12);
      drive_byte(1'b1, 8'h34);
      drive_byte(1'b1, 8'hDE);
      drive_byte(1'b1, 8'hAD);
      drive_byte(1'b1, 8'hBE);
      drive_byte(1'b1, 8'hEF);
      push(1'b1, 1'b0, 8'h01, 32'h0000_1234, 64'hDEAD_BEEF, 2'b00, cyc + 1);
      idle();
      wait_drain(1'b1, 20);

      // Reset in the middle of a frame.
      drive_byte(1'b0, 8'hA5);
      drive_byte(1'b0, 8'h10);
      idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      l_code = 2'b00;
      frame_d(8'h11, 8'h22, 8'h33, 8'h00, 1'b1);
      idle();
      wait_drain(1'b0, 20);

      repeat (5) @(negedge clk);
      cmp("end_queue_def",  64'(q_d.size()), 64'(0));
      cmp("end_queue_wide", 64'(q_w.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/manager_rx_frame.md
Name: manager_rx_frame

Overview:
- Parametrised receive-frame assembler between the UART receiver (byte + done strobe) and the command manager.
- Collects one command byte, ADDR_BYTES address bytes, DATA_BYTES data bytes and an optional XOR checksum byte.
- Presents the registered fields with a one-cycle frame_valid pulse.
- Adds an inter-byte timeout, checksum checking and error reporting; only complete, good frames update the outputs.

Parameters:
- ADDR_BYTES, 1, number of address bytes per frame (legal 1..4).
- DATA_BYTES, 1, number of data bytes per frame (legal 1..8).
- CHECKSUM_EN, 1, 1 = frame ends with an XOR checksum byte; 0 = no checksum byte.
- TIMEOUT_CYCLES, 50000, maximum clock cycles allowed between bytes inside a frame (1 ms at 50 MHz); 0 disables the timeout.

Ports:
- CLK_50MHZ  in  1  system clock, all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- RS_DATAOUT  in  8  received byte; valid only in a cycle where RS_DONE=1.
- RS_DONE  in  1  one-cycle strobe: a new byte is present on RS_DATAOUT.
- frame_valid  out  1  one-cycle pulse: a good frame has been latched on cmd_rx/addr_rx/data_rx.
- cmd_rx  out  8  command byte of the last good frame.
- addr_rx  out  8*ADDR_BYTES  address of the last good frame, first received byte = MSB.
- data_rx  out  8*DATA_BYTES  data of the last good frame, first received byte = MSB.
- frame_err  out  1  one-cycle pulse: the frame was discarded.
- err_code  out  2  cause of the last error, held until the next error: 01 = checksum mismatch, 10 = timeout.
- busy  out  1  high while a frame is partly received (state is not S_CMD).

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state = S_CMD; byte counter, timeout counter and running checksum = 0.
  - All outputs = 0.
  - Any partial frame is discarded; no frame_err is generated for it.
- Byte capture: a byte is accepted on the rising edge where RS_DONE=1. No other cycle samples RS_DATAOUT.
- Shadow registers assemble the frame. They shift left by 8 and insert the new byte, giving big-endian order.
- Running checksum = XOR of the cmd, address and data bytes.
- States:
  - S_CMD: on RS_DONE, store cmd, set checksum = byte, go to S_ADDR with counter = 0.
  - S_ADDR: on RS_DONE, shift the byte into the address shadow. After byte ADDR_BYTES, go to S_DATA with counter = 0.
  - S_DATA: on RS_DONE, shift the byte into the data shadow. After byte DATA_BYTES, go to S_CSUM if CHECKSUM_EN=1, otherwise commit.
  - S_CSUM: on RS_DONE, compare the byte with the running checksum. Equal = commit. Different = frame_err=1, err_code=01, go to S_CMD, outputs unchanged.
- Commit:
  - On the edge that accepts the final byte, copy the shadows to cmd_rx/addr_rx/data_rx.
  - In the same edge, set frame_valid=1 for exactly one cycle and return to S_CMD.
  - Latency from the final RS_DONE to frame_valid is 1 cycle.
- Back-to-back frames: an RS_DONE in the cycle where frame_valid=1 is accepted as the next cmd byte. No dead cycles.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on every accepted byte and increments each cycle while state is not S_CMD.
  - When it reaches TIMEOUT_CYCLES with no RS_DONE: frame_err=1, err_code=10, state = S_CMD, shadows dropped, outputs unchanged.
  - If RS_DONE and expiry fall in the same cycle, the byte wins: it is accepted and no timeout is raised.
  - The counter does not run in S_CMD, so an idle line never raises an error.
- frame_valid and frame_err are never high together.
- Outputs cmd_rx/addr_rx/data_rx hold their value until the next good frame.
- Counter widths are sized with $clog2 from the parameters. No wrap-around occurs, because each counter clears before its terminal value.

Test Plan:
- Defaults; send A5,10,3C,89 (89 = A5^10^3C) -> one cycle after the last RS_DONE: frame_valid=1, cmd_rx=A5, addr_rx=10, data_rx=3C, frame_err=0.
- Defaults after a good frame; send 01,02,03,FF (expected 00) -> frame_err pulse, err_code=01, outputs still A5/10/3C, no frame_valid.
- Defaults; send A5,10, then no strobe for 50000 cycles -> frame_err with err_code=10 and busy=0. A following frame 11,22,33,00 then gives frame_valid with cmd=11, addr=22, data=33.
- ADDR_BYTES=2, DATA_BYTES=4, CHECKSUM_EN=0; send 01,12,34,DE,AD,BE,EF -> frame_valid, cmd_rx=01, addr_rx=1234, data_rx=DEADBEEF.
- Defaults; two frames with RS_DONE for the second cmd in the frame_valid cycle -> both frames are reported, the second with its own values, no error.
- Defaults; send A5,10, pulse RST_N low for 3 cycles mid-frame, then send 11,22,33,00 -> outputs 0 during reset, no frame_err, then a single frame_valid with cmd=11.
